// File: rtl/mp_util_pkg.sv
// Shared helpers for the multi-port FIFO family: lane counting and width helpers.
// Lane vectors are handled up to MAX_W bits; callers zero-extend narrower vectors.
package mp_util_pkg;

    localparam int MAX_W = 32;

    typedef logic [MAX_W-1:0] lane_vec_t;
    typedef logic [5:0]       lane_cnt_t;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic lane_cnt_t popcount(input lane_vec_t v);
        lane_cnt_t c;
        c = '0;
        for (int i = 0; i < MAX_W; i++) begin
            c = c + lane_cnt_t'(v[i]);
        end
        return c;
    endfunction

    // Length of the run of ones starting at bit 0.
    function automatic lane_cnt_t lead_ones(input lane_vec_t v);
        lane_cnt_t c;
        logic      run;
        c   = '0;
        run = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            run = run & v[i];
            c   = c + lane_cnt_t'(run);
        end
        return c;
    endfunction

endpackage

// File: rtl/mp_enq_compactor_if.sv
// Enqueue-side bundle: sparse request lanes in, compacted prefix lanes out.
// The slave side is the compactor, the master side is its environment.
interface mp_enq_compactor_if #(
    parameter int PAYLOAD_WIDTH = 3,
    parameter int WIDTH         = 4
);
    logic [WIDTH-1:0]                    in_vld_i;
    logic [WIDTH-1:0][PAYLOAD_WIDTH-1:0] in_payload_i;
    logic                                in_rdy_o;
    logic [WIDTH-1:0]                    out_vld_o;
    logic [WIDTH-1:0][PAYLOAD_WIDTH-1:0] out_payload_o;
    logic [WIDTH-1:0]                    out_rdy_i;
    logic                                flush_i;

    modport master (
        output in_vld_i, in_payload_i, out_rdy_i, flush_i,
        input  in_rdy_o, out_vld_o, out_payload_o
    );

    modport slave (
        input  in_vld_i, in_payload_i, out_rdy_i, flush_i,
        output in_rdy_o, out_vld_o, out_payload_o
    );
endinterface

// File: rtl/mp_enq_compactor_prefix_compactor.sv
// Combinational lane compactor: set lanes of vld_i are packed into lanes 0..cnt_o-1,
// lowest source lane first, by selecting on the running prefix count.
module prefix_compactor
    import mp_util_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 3,
    parameter int WIDTH         = 4
) (
    input  logic [WIDTH-1:0]                    vld_i,
    input  logic [WIDTH-1:0][PAYLOAD_WIDTH-1:0] payload_i,
    output logic [WIDTH-1:0][PAYLOAD_WIDTH-1:0] payload_o,
    output logic [cnt_w(WIDTH)-1:0]             cnt_o
);
    localparam int CW = cnt_w(WIDTH);

    logic [CW-1:0] pre;

    always_comb begin
        payload_o = '0;
        pre       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j <= i; j++) begin
                if (vld_i[i] && pre == CW'(j)) begin
                    payload_o[j] = payload_i[i];
                end
            end
            pre = pre + CW'(vld_i[i]);
        end
    end

    assign cnt_o = CW'(popcount(MAX_W'(vld_i)));

endmodule

// File: rtl/mp_enq_compactor.sv
// Registered enqueue compactor: holds a dense group and releases it through a
// prefix-shaped handshake, shifting untaken entries down for re-offer.
module mp_enq_compactor
    import mp_util_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 3,
    parameter int WIDTH         = 4
) (
    input logic               clk,
    input logic               rst,
    mp_enq_compactor_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);

    typedef logic [PAYLOAD_WIDTH-1:0] pay_t;

    logic [CW-1:0]    cnt_q, cnt_d;
    pay_t [WIDTH-1:0] buf_q, buf_d;
    pay_t [WIDTH-1:0] dense;
    logic [CW-1:0]    in_cnt;
    logic [CW-1:0]    take_m;
    logic [WIDTH-1:0] vld;
    logic             in_rdy;
    logic             in_fire;

    prefix_compactor #(
        .PAYLOAD_WIDTH(PAYLOAD_WIDTH),
        .WIDTH        (WIDTH)
    ) u_compact (
        .vld_i    (bus.in_vld_i),
        .payload_i(bus.in_payload_i),
        .payload_o(dense),
        .cnt_o    (in_cnt)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_vld
        assign vld[i] = cnt_q > CW'(i);
    end

    // Only the leading run of ready lanes counts as taken.
    assign take_m  = CW'(lead_ones(MAX_W'(vld & bus.out_rdy_i)));
    assign in_rdy  = !bus.flush_i && (take_m == cnt_q);
    assign in_fire = in_rdy && |bus.in_vld_i;

    assign bus.in_rdy_o      = in_rdy;
    assign bus.out_vld_o     = vld;
    assign bus.out_payload_o = buf_q;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (bus.flush_i) begin
            cnt_d = '0;
        end else if (in_fire) begin
            buf_d = dense;
            cnt_d = in_cnt;
        end else begin
            cnt_d = cnt_q - take_m;
            for (int j = 0; j < WIDTH; j++) begin
                for (int s = 1; s < WIDTH - j; s++) begin
                    if (take_m == CW'(s)) begin
                        buf_d[j] = buf_q[j+s];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Payload storage carries no reset; validity comes from cnt_q alone.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule
